vlg_echo: RTL and testbench
===========================

Name: vlg_echo

Overview:
- Receive side of the ultrasonic ranging interface; pairs with the existing 10 us / 100 ms trigger generator.
- Measures the width of the sensor's echo pulse in microseconds and converts it to centimetres with an on-the-fly sequential divide (58 us per cm).
- Reports a one-cycle valid or timeout pulse per measurement.
- Sits between the sensor echo pin and the display/UART consumers, sharing the same 1 us clock enable as the trigger block.

Parameters:
- P_US_PER_CM, 58, microsecond ticks per centimetre (round-trip sound time).
- P_TIMEOUT_US, 38000, echo-high duration in us at which the measurement is abandoned.
- P_US_W, 16, width of the microsecond counter and o_echo_us.
- P_CM_W, 10, width of the centimetre counter and o_dist_cm.

Ports:
- i_clk  input  1  system clock (50 MHz nominal).
- i_rst_n  input  1  reset; asynchronous assert, active-low.
- i_clk_en  input  1  one-cycle 1 us tick, the same enable that drives the trigger generator.
- i_echo  input  1  raw asynchronous echo pin from the sensor.
- o_echo_us  output  P_US_W  last valid pulse width in us.
- o_dist_cm  output  P_CM_W  last valid distance in cm, truncated.
- o_valid  output  1  one-cycle pulse when o_echo_us/o_dist_cm update.
- o_timeout  output  1  one-cycle pulse on abandoned measurement.

Behaviour:
- Reset: all outputs 0, all counters 0, FSM to IDLE, sync flops 0. Reset is asynchronous and active-low on every flop.
- Input sync: 2-flop synchronizer (s1, s2) plus a delayed copy d.
  - rise = s2 & ~d
  - fall = ~s2 & d
- FSM states:
  - IDLE: wait for rise. On rise, clear us_cnt, sub_cnt and cm_cnt, then go to MEASURE.
  - MEASURE, on each i_clk_en:
    - us_cnt += 1 and sub_cnt += 1.
    - When sub_cnt == P_US_PER_CM-1, set sub_cnt to 0 and cm_cnt += 1.
  - MEASURE, on fall: latch o_echo_us = us_cnt and o_dist_cm = cm_cnt, pulse o_valid, go to IDLE.
  - MEASURE, timeout: when us_cnt == P_TIMEOUT_US and echo is still high, pulse o_timeout, go to WAIT_LOW. Outputs keep their previous values.
  - WAIT_LOW: ignore the echo until s2 == 0, then go to IDLE. No output pulse.
- Latency: o_valid is high during the clock after the 3rd rising i_clk edge, counting the edge that first samples i_echo low as the 1st.
- Simultaneous fall and i_clk_en in MEASURE: fall wins. The tick is not counted.
- Simultaneous fall and timeout condition: fall wins, giving o_valid with us_cnt = P_TIMEOUT_US.
- Echo already high when reset releases: no rise is seen, so the pulse is ignored and the block stays in IDLE until the next rising edge.
- Reset mid-measurement: abort immediately with no output pulse.
- o_valid and o_timeout are never high in the same cycle. Each pulse lasts exactly one i_clk.
- Counters saturate-free by construction, since P_TIMEOUT_US < 2^P_US_W and P_TIMEOUT_US/P_US_PER_CM < 2^P_CM_W.
- Without i_clk_en the counters hold. Edges are still detected on every i_clk.

Decomposition:
- Package vlg_echo_pkg: FSM state encoding (IDLE, MEASURE, WAIT_LOW), P_US_PER_CM, P_TIMEOUT_US, width constants.
- Sub-module vlg_sync_edge: 2-flop synchronizer plus rise/fall detect, with async active-low reset. It is reusable for other sensor inputs.
- The FSM, counters and output registers stay in vlg_echo.

Test Plan (50 MHz clock, i_clk_en every 50 clocks):
- Echo high for 580 ticks -> o_valid pulse once, o_echo_us=580, o_dist_cm=10, o_timeout stays 0.
- Echo high for 57 ticks, then 58 ticks -> first o_dist_cm=0 with o_echo_us=57; second o_dist_cm=1 with o_echo_us=58.
- Echo high for 40000 ticks -> o_timeout pulse when us_cnt reaches 38000, no o_valid, outputs unchanged. Then a 1160-tick pulse -> o_echo_us=1160, o_dist_cm=20.
- Echo held high across reset release, then low, then a 290-tick pulse -> the first pulse is ignored; a single o_valid with o_echo_us=290, o_dist_cm=5.
- Reset asserted at tick 300 of a pulse, released, echo drops -> no o_valid or o_timeout. Outputs read 0. The next 116-tick pulse gives o_dist_cm=2.
- Falling edge aligned with an i_clk_en cycle at tick 100 -> o_echo_us=100 with the tick not counted. o_valid latency is exactly 3 clocks from the pin-sampling edge.

Source files
------------

// File: rtl/vlg_echo_pkg.sv
// Shared definitions for the ultrasonic echo receiver.
//   - Default timing constants: microseconds per centimetre and the
//     abandon threshold.
//   - Default counter widths.
//   - Measurement FSM state encoding.
package vlg_echo_pkg;

  localparam int unsigned C_US_PER_CM  = 58;     // round-trip sound time per cm
  localparam int unsigned C_TIMEOUT_US = 38000;  // echo-high time that abandons a measurement
  localparam int unsigned C_US_W       = 16;     // microsecond counter width
  localparam int unsigned C_CM_W       = 10;     // centimetre counter width

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,  // waiting for the echo rising edge
    ST_MEASURE  = 2'd1,  // counting microseconds and centimetres
    ST_WAIT_LOW = 2'd2   // abandoned pulse: wait for the pin to return low
  } echo_state_t;

endpackage

// File: rtl/vlg_sync_edge.sv
// Two-flop synchronizer with rise/fall detection for an asynchronous pin.
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_async  : raw asynchronous input
//   o_level  : synchronized level (second synchronizer flop)
//   o_rise   : one-cycle pulse on a synchronized 0->1 transition
//   o_fall   : one-cycle pulse on a synchronized 1->0 transition
// Edges are reported only once the delayed copy holds a real sample, so a
// pin that is already high when reset releases does not look like a rise.
module vlg_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic       r_s1;
  logic       r_s2;
  logic       r_d;
  logic [2:0] r_vld;  // fills with ones as s1, s2 and d take real samples

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour and the chain shifts by one stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_d   <= 1'b0;
      r_vld <= '0;
    end else begin
      r_s1  <= i_async;
      r_s2  <= r_s1;
      r_d   <= r_s2;
      r_vld <= {r_vld[1:0], 1'b1};
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_vld[2] &  r_s2 & ~r_d;
  assign o_fall  = r_vld[2] & ~r_s2 &  r_d;

endmodule

// File: rtl/vlg_echo.sv
// Ultrasonic echo receiver: measures the echo pulse width in microseconds
// and converts it to centimetres while counting (one cm every P_US_PER_CM
// ticks), so no divider is needed.
//   i_clk     : system clock
//   i_rst_n   : asynchronous active-low reset
//   i_clk_en  : one-cycle 1 us tick
//   i_echo    : raw asynchronous echo pin
//   o_echo_us : last valid pulse width in us
//   o_dist_cm : last valid distance in cm (truncated)
//   o_valid   : one-cycle pulse when o_echo_us/o_dist_cm update
//   o_timeout : one-cycle pulse when a measurement is abandoned
module vlg_echo
  import vlg_echo_pkg::*;
#(
  parameter int unsigned P_US_PER_CM  = C_US_PER_CM,
  parameter int unsigned P_TIMEOUT_US = C_TIMEOUT_US,
  parameter int unsigned P_US_W       = C_US_W,
  parameter int unsigned P_CM_W       = C_CM_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clk_en,
  input  logic              i_echo,
  output logic [P_US_W-1:0] o_echo_us,
  output logic [P_CM_W-1:0] o_dist_cm,
  output logic              o_valid,
  output logic              o_timeout
);

  localparam int unsigned L_SUB_W = $clog2(P_US_PER_CM);

  echo_state_t         r_state;
  logic [P_US_W-1:0]   r_us_cnt;
  logic [L_SUB_W-1:0]  r_sub_cnt;  // ticks into the current centimetre
  logic [P_CM_W-1:0]   r_cm_cnt;
  logic [P_US_W-1:0]   r_echo_us;
  logic [P_CM_W-1:0]   r_dist_cm;
  logic                r_valid;
  logic                r_timeout;

  logic w_level;
  logic w_rise;
  logic w_fall;

  vlg_sync_edge u_sync_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_echo),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_us_cnt  <= '0;
      r_sub_cnt <= '0;
      r_cm_cnt  <= '0;
      r_echo_us <= '0;
      r_dist_cm <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_us_cnt  <= '0;
            r_sub_cnt <= '0;
            r_cm_cnt  <= '0;
            r_state   <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          // Priority: fall, then timeout, then tick. A tick coinciding with
          // the fall is dropped; a fall at the threshold still reports.
          if (w_fall) begin
            r_echo_us <= r_us_cnt;
            r_dist_cm <= r_cm_cnt;
            r_valid   <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (w_level && (r_us_cnt == P_US_W'(P_TIMEOUT_US))) begin
            r_timeout <= 1'b1;
            r_state   <= ST_WAIT_LOW;
          end else if (i_clk_en) begin
            r_us_cnt <= r_us_cnt + P_US_W'(1);
            if (r_sub_cnt == L_SUB_W'(P_US_PER_CM - 1)) begin
              r_sub_cnt <= '0;
              r_cm_cnt  <= r_cm_cnt + P_CM_W'(1);
            end else begin
              r_sub_cnt <= r_sub_cnt + L_SUB_W'(1);
            end
          end
        end
        ST_WAIT_LOW: begin
          if (!w_level) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_echo_us = r_echo_us;
  assign o_dist_cm = r_dist_cm;
  assign o_valid   = r_valid;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_vlg_echo.sv
`timescale 1ns/1ps
// Directed bench for vlg_echo: expected measurements are queued when a
// pulse is driven and compared when the DUT pulses o_valid/o_timeout.
module tb_vlg_echo;

  localparam int US_PER_CM = 58;
  localparam int EN_PERIOD = 5;   // clocks per 1 us tick in normal steps

  typedef struct {
    bit tmo;
    int us;
    int cm;
  } exp_t;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_clk_en;
  logic        i_echo;
  logic [15:0] o_echo_us;
  logic [9:0]  o_dist_cm;
  logic        o_valid;
  logic        o_timeout;

  int   errors;
  int   checks;
  int   last_us;
  int   last_cm;
  exp_t sb[$];
  exp_t mon_e;

  vlg_echo dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clk_en  (i_clk_en),
    .i_echo    (i_echo),
    .o_echo_us (o_echo_us),
    .o_dist_cm (o_dist_cm),
    .o_valid   (o_valid),
    .o_timeout (o_timeout)
  );

  initial i_clk = 1'b0;
  always #10 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    i_clk_en = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  // n ticks, each a single-clock enable after (period-1) quiet clocks.
  task automatic run_ticks(input int n, input int period);
    repeat (n) begin
      i_clk_en = 1'b0;
      repeat (period - 1) @(negedge i_clk);
      i_clk_en = 1'b1;
      @(negedge i_clk);
    end
    i_clk_en = 1'b0;
  endtask

  task automatic push_valid(input int us);
    exp_t e;
    e.tmo = 1'b0;
    e.us  = us;
    e.cm  = us / US_PER_CM;
    sb.push_back(e);
    last_us = e.us;
    last_cm = e.cm;
  endtask

  task automatic push_timeout();
    exp_t e;
    e.tmo = 1'b1;
    e.us  = last_us;
    e.cm  = last_cm;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    check(tag, 32'(sb.size()), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_us"},      32'(o_echo_us), 0);
    check({tag, "_cm"},      32'(o_dist_cm), 0);
    check({tag, "_valid"},   32'(o_valid),   0);
    check({tag, "_timeout"}, 32'(o_timeout), 0);
  endtask

  task automatic pulse(input int n, input string tag);
    push_valid(n);
    i_echo = 1'b1;
    run_ticks(n, EN_PERIOD);
    i_echo = 1'b0;
    idle(2);
    wait_drain(tag);
    idle(5);
  endtask

  // Scoreboard side: every output pulse must match the oldest expectation.
  always @(negedge i_clk) begin
    if (o_valid || o_timeout) begin
      check("pulse_exclusive", 32'(o_valid & o_timeout), 0);
      check("pulse_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("pulse_kind_timeout", 32'(o_timeout), 32'(mon_e.tmo));
        check("pulse_echo_us", 32'(o_echo_us), 32'(mon_e.us));
        check("pulse_dist_cm", 32'(o_dist_cm), 32'(mon_e.cm));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors   = 0;
    checks   = 0;
    last_us  = 0;
    last_cm  = 0;
    i_rst_n  = 1'b0;
    i_clk_en = 1'b0;
    i_echo   = 1'b0;
    idle(5);
    check_zero("reset");
    i_rst_n = 1'b1;
    idle(5);

    // 580 us -> 10 cm
    pulse(580, "drain_580");

    // centimetre boundary: 57 us -> 0 cm, 58 us -> 1 cm
    pulse(57, "drain_57");
    pulse(58, "drain_58");

    // 40000 us echo: timeout at 38000, outputs held at the previous result
    push_timeout();
    i_echo = 1'b1;
    idle(4);
    run_ticks(38000, 1);
    run_ticks(200, 1);
    wait_drain("drain_timeout");
    i_echo = 1'b0;
    idle(10);
    check("after_timeout_us", 32'(o_echo_us), 58);
    check("after_timeout_cm", 32'(o_dist_cm), 1);
    check("after_timeout_pending", 32'(sb.size()), 0);
    pulse(1160, "drain_1160");

    // echo already high when reset releases: that pulse is ignored
    i_rst_n = 1'b0;
    i_echo  = 1'b1;
    idle(3);
    last_us = 0;
    last_cm = 0;
    check_zero("reset_high");
    i_rst_n = 1'b1;
    idle(10);
    i_echo = 1'b0;
    idle(10);
    check("ignored_pulse_pending", 32'(sb.size()), 0);
    check("ignored_pulse_us", 32'(o_echo_us), 0);
    pulse(290, "drain_290");

    // reset in the middle of a measurement: no pulse, outputs cleared
    i_echo = 1'b1;
    run_ticks(300, EN_PERIOD);
    i_rst_n = 1'b0;
    last_us = 0;
    last_cm = 0;
    #1;
    check_zero("reset_mid");
    idle(3);
    i_rst_n = 1'b1;
    idle(5);
    i_echo = 1'b0;
    idle(10);
    check_zero("after_abort");
    pulse(116, "drain_116");

    // fall coincides with an enable at the deciding edge: tick dropped,
    // o_valid exactly on the 3rd edge from the one sampling the pin low
    push_valid(100);
    i_echo = 1'b1;
    run_ticks(100, EN_PERIOD);
    i_echo   = 1'b0;
    i_clk_en = 1'b0;
    @(negedge i_clk);
    check("latency_edge1", 32'(o_valid), 0);
    i_clk_en = 1'b0;
    @(negedge i_clk);
    check("latency_edge2", 32'(o_valid), 0);
    i_clk_en = 1'b1;
    @(negedge i_clk);
    i_clk_en = 1'b0;
    check("latency_edge3", 32'(o_valid), 1);
    @(negedge i_clk);
    check("latency_edge4", 32'(o_valid), 0);
    wait_drain("drain_aligned");
    check("aligned_us", 32'(o_echo_us), 100);
    check("aligned_cm", 32'(o_dist_cm), 1);
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
